// File: rtl/wb_dmem_if.sv
// Wishbone classic data-memory bus: one master, one responder.
interface wb_dmem_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_dmem_responder.sv
// Wishbone classic data memory with optional wait states and a tohost
// mailbox word that latches a pass/fail verdict from the running program.
module wb_dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TOHOST_WORD = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_dmem_if.slave    wb,
    output logic        done_o,
    output logic        pass_o,
    output logic [30:0] fail_code_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0]      WAIT_LOAD  = CNT_W'(WAIT_STATES - 1);
    localparam logic [ADDR_WIDTH-1:0] TOHOST_IDX = ADDR_WIDTH'(TOHOST_WORD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [29:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [30:0]        fail_q, fail_d;

    logic [31:0]        mem_q [DEPTH];

    logic               in_idle_c;
    logic               req_c;
    logic [29:0]        req_adr_c;
    logic [31:0]        req_dat_c;
    logic               req_we_c;
    logic [3:0]         req_sel_c;
    logic [ADDR_WIDTH-1:0] idx_c;
    logic               oor_c;
    logic [31:0]        mem_rd_c;
    logic [31:0]        merged_c;
    logic               commit_c;
    logic               mem_wr_c;
    logic               unused_adr_lsb_c;

    // Byte-offset bits carry no meaning for a word memory.
    assign unused_adr_lsb_c = ^wb.wb_adr_i[1:0];

    // Zero-wait responses are decided from the live bus, otherwise from the latched request.
    assign in_idle_c = (state_q == S_IDLE);
    assign req_c     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign req_adr_c = in_idle_c ? wb.wb_adr_i[31:2] : adr_q;
    assign req_dat_c = in_idle_c ? wb.wb_dat_i       : dat_q;
    assign req_we_c  = in_idle_c ? wb.wb_we_i        : we_q;
    assign req_sel_c = in_idle_c ? wb.wb_sel_i       : sel_q;
    assign idx_c     = req_adr_c[ADDR_WIDTH-1:0];
    assign oor_c     = (req_adr_c >> ADDR_WIDTH) != '0;
    assign mem_rd_c  = mem_q[idx_c];

    // Byte-lane merge of write data over the current word.
    always_comb begin
        merged_c = mem_rd_c;
        for (int b = 0; b < 4; b++) begin
            if (req_sel_c[b]) begin
                merged_c[8*b +: 8] = req_dat_c[8*b +: 8];
            end
        end
    end

    // Next-state, request latching and response generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        we_d     = we_q;
        sel_d    = sel_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        commit_c = 1'b0;
        mem_wr_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    adr_d = wb.wb_adr_i[31:2];
                    dat_d = wb.wb_dat_i;
                    we_d  = wb.wb_we_i;
                    sel_d = wb.wb_sel_i;
                    if (WAIT_STATES == 0) begin
                        state_d  = S_RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!(wb.wb_cyc_i && wb.wb_stb_i)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d  = S_RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit_c) begin
            if (oor_c) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (req_we_c) begin
                    mem_wr_c = rst_n;
                    if ((idx_c == TOHOST_IDX) && (merged_c != '0) && !done_q) begin
                        done_d = 1'b1;
                        pass_d = (merged_c == 32'd1);
                        fail_d = merged_c[31:1];
                    end
                end else begin
                    rdata_d = mem_rd_c;
                end
            end
        end
    end

    // Control and response registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    // Storage array; preloaded externally and deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_wr_c) begin
            mem_q[idx_c] <= merged_c;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = rdata_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_code_o = fail_q;

endmodule

// File: tb/tb_wb_dmem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) driven by random
// and directed transfers, checked against a word-level memory model.
module tb_wb_dmem_responder;

    localparam int unsigned AW    = 13;
    localparam int          NPOOL = 11;

    typedef struct {
        int          due;
        bit          is_err;
        logic [31:0] dat;
        bit          done;
        bit          pass;
        logic [30:0] fail;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc_cnt;
    int   checks;
    int   failures;

    wb_dmem_if bus0 ();
    wb_dmem_if bus3 ();

    logic        done0, pass0, done3, pass3;
    logic [30:0] fail0, fail3;

    wb_dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0), .TOHOST_WORD(1024)) dut0 (
        .clk(clk), .rst_n(rst_n), .wb(bus0),
        .done_o(done0), .pass_o(pass0), .fail_code_o(fail0)
    );

    wb_dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(3), .TOHOST_WORD(1024)) dut3 (
        .clk(clk), .rst_n(rst_n), .wb(bus3),
        .done_o(done3), .pass_o(pass3), .fail_code_o(fail3)
    );

    // Reference model state, indexed by bench-side DUT number (0 or 1).
    int          pool [NPOOL] = '{0, 1, 2, 5, 7, 100, 1023, 1024, 1025, 4000, 8191};
    logic [31:0] mem_m  [2][NPOOL];
    bit          done_m [2];
    bit          pass_m [2];
    logic [30:0] fail_m [2];
    logic [31:0] rd_m   [2];
    exp_t        q0 [$];
    exp_t        q1 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    function automatic int wait_states(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic drive(input int d, input bit cyc, input bit stb, input bit we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (d == 0) begin
            bus0.wb_cyc_i = cyc; bus0.wb_stb_i = stb; bus0.wb_we_i = we;
            bus0.wb_adr_i = adr; bus0.wb_dat_i = dat; bus0.wb_sel_i = sel;
        end else begin
            bus3.wb_cyc_i = cyc; bus3.wb_stb_i = stb; bus3.wb_we_i = we;
            bus3.wb_adr_i = adr; bus3.wb_dat_i = dat; bus3.wb_sel_i = sel;
        end
    endtask

    task automatic sample(input int d, output logic ack, output logic err, output logic [31:0] dat,
                          output logic done, output logic pass, output logic [30:0] fail);
        if (d == 0) begin
            ack = bus0.wb_ack_o; err = bus0.wb_err_o; dat = bus0.wb_dat_o;
            done = done0; pass = pass0; fail = fail0;
        end else begin
            ack = bus3.wb_ack_o; err = bus3.wb_err_o; dat = bus3.wb_dat_o;
            done = done3; pass = pass3; fail = fail3;
        end
    endtask

    function automatic int find_slot(input int word);
        for (int s = 0; s < NPOOL; s++) begin
            if (pool[s] == word) return s;
        end
        return -1;
    endfunction

    // Model the transfer, queue its expected response, run the handshake.
    task automatic xfer(input int d, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
        exp_t        e;
        int          slot;
        logic [31:0] val;
        logic        a, er, dn, ps;
        logic [31:0] dt;
        logic [30:0] fc;
        bit          got;

        e.is_err = (adr >> (AW + 2)) != 0;
        if (!e.is_err) begin
            slot = find_slot(int'(adr[AW+1:2]));
            if (slot < 0) begin
                $display("FAIL bench_address %h outside modelled pool", adr);
                $fatal(1, "bench address");
            end
            if (we) begin
                val = mem_m[d][slot];
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) val[8*b +: 8] = dat[8*b +: 8];
                end
                mem_m[d][slot] = val;
                if (pool[slot] == 1024 && val != 0 && !done_m[d]) begin
                    done_m[d] = 1'b1;
                    pass_m[d] = (val == 32'd1);
                    fail_m[d] = val[31:1];
                end
            end else begin
                rd_m[d] = mem_m[d][slot];
            end
        end
        e.dat  = rd_m[d];
        e.done = done_m[d];
        e.pass = pass_m[d];
        e.fail = fail_m[d];

        drive(d, 1'b1, 1'b1, we, adr, dat, sel);
        e.due = cyc_cnt + 1 + wait_states(d);
        if (d == 0) q0.push_back(e); else q1.push_back(e);

        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            sample(d, a, er, dt, dn, ps, fc);
            got = a | er;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL d%0d_timeout actual=no_response required=ack_or_err adr=%h", d, adr);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Write accepted into WAIT, then strobe withdrawn one cycle later.
    task automatic abort_write(input logic [31:0] adr, input logic [31:0] dat);
        drive(1, 1'b1, 1'b1, 1'b1, adr, dat, 4'hF);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            logic a, er, dn, ps;
            logic [31:0] dt;
            logic [30:0] fc;
            sample(d, a, er, dt, dn, ps, fc);
            chk($sformatf("%s_d%0d_ack", tag, d), 32'(a), 32'd0);
            chk($sformatf("%s_d%0d_err", tag, d), 32'(er), 32'd0);
            chk($sformatf("%s_d%0d_dat", tag, d), dt, 32'd0);
            chk($sformatf("%s_d%0d_done", tag, d), 32'(dn), 32'd0);
            chk($sformatf("%s_d%0d_pass", tag, d), 32'(ps), 32'd0);
            chk($sformatf("%s_d%0d_fail", tag, d), 32'(fc), 32'd0);
        end
    endtask

    // Compare whatever a DUT presents against the head of its queue.
    task automatic monitor_one(input int d);
        logic a, er, dn, ps;
        logic [31:0] dt;
        logic [30:0] fc;
        exp_t e;
        int   n;
        sample(d, a, er, dt, dn, ps, fc);
        n = (d == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            if (e.due < cyc_cnt) begin
                checks++;
                failures++;
                $display("FAIL d%0d_late actual=none_by_cycle_%0d required=resp_at_%0d", d, cyc_cnt, e.due);
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                n--;
            end
        end
        if (a || er) begin
            if (n == 0) begin
                checks++;
                failures++;
                $display("FAIL d%0d_spurious actual=ack%0b_err%0b required=idle", d, a, er);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("d%0d_due", d), 32'(cyc_cnt), 32'(e.due));
                chk($sformatf("d%0d_both", d), 32'(a & er), 32'd0);
                chk($sformatf("d%0d_ack", d), 32'(a), 32'(!e.is_err));
                chk($sformatf("d%0d_err", d), 32'(er), 32'(e.is_err));
                chk($sformatf("d%0d_dat", d), dt, e.dat);
                chk($sformatf("d%0d_done", d), 32'(dn), 32'(e.done));
                chk($sformatf("d%0d_pass", d), 32'(ps), 32'(e.pass));
                chk($sformatf("d%0d_failcode", d), 32'(fc), 32'(e.fail));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            monitor_one(0);
            monitor_one(1);
        end
    end

    initial begin
        logic [31:0] adr;
        logic [31:0] dat;
        int          s;
        int          r;
        bit          we;

        checks   = 0;
        failures = 0;
        cyc_cnt  = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            done_m[d] = 1'b0;
            pass_m[d] = 1'b0;
            fail_m[d] = '0;
            rd_m[d]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Environment preload of every modelled word; mailbox starts at zero.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NPOOL; k++) begin
                xfer(d, 1'b1, 32'(pool[k]) << 2, (pool[k] == 1024) ? 32'h0 : $urandom, 4'hF);
            end
            xfer(d, 1'b1, 32'h14, 32'h1122_3344, 4'hF);
        end

        // Zero-wait read, partial-lane write, mailbox fail code, out-of-range read.
        xfer(0, 1'b0, 32'h14, 32'h0, 4'hF);
        xfer(0, 1'b1, 32'h14, 32'hAABB_CCDD, 4'b0110);
        xfer(0, 1'b0, 32'h14, 32'h0, 4'hF);
        xfer(0, 1'b1, 32'h14, 32'h5555_5555, 4'b0000);
        xfer(0, 1'b0, 32'h14, 32'h0, 4'hF);
        xfer(0, 1'b1, 32'h1000, 32'h0, 4'hF);
        xfer(0, 1'b1, 32'h1000, 32'h0000_000B, 4'hF);
        xfer(0, 1'b1, 32'h1000, 32'h0000_0001, 4'hF);
        xfer(0, 1'b0, 32'h0001_0000, 32'h0, 4'hF);

        // Three-wait mailbox pass, then a sticky check with a later value.
        xfer(1, 1'b1, 32'h1000, 32'h0000_0001, 4'hF);
        xfer(1, 1'b1, 32'h1000, 32'h0000_0007, 4'hF);
        xfer(1, 1'b0, 32'h1000, 32'h0, 4'hF);
        abort_write(32'h14, 32'hCAFE_F00D);
        xfer(1, 1'b0, 32'h14, 32'h0, 4'hF);

        // Reset pulse while a write sits in WAIT.
        drive(1, 1'b1, 1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int d = 0; d < 2; d++) begin
            done_m[d] = 1'b0;
            pass_m[d] = 1'b0;
            fail_m[d] = '0;
            rd_m[d]   = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 32'h14, 32'h0, 4'hF);
        xfer(0, 1'b0, 32'h14, 32'h0, 4'hF);

        // Randomized traffic on both responders.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                r   = $urandom_range(0, 99);
                s   = $urandom_range(0, NPOOL - 1);
                we  = 1'($urandom_range(0, 1));
                adr = {20'(pool[s]) << 2} | 32'($urandom_range(0, 3));
                dat = $urandom;
                if (pool[s] == 1024) begin
                    case ($urandom_range(0, 3))
                        0: dat = 32'h0;
                        1: dat = 32'h1;
                        2: dat = 32'(2 * $urandom_range(1, 100) + 1);
                        default: dat = $urandom;
                    endcase
                end
                if (d == 1 && r < 8) begin
                    abort_write(adr, dat);
                end else begin
                    if (r < 22) adr = $urandom | (32'h1 << $urandom_range(AW + 2, 31));
                    xfer(d, we, adr, dat, 4'($urandom_range(0, 15)));
                end
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (8) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_dmem_responder.md
WB_DMEM_RESPONDER -- requirements
Module: wb_dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, word-address bits; memory depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 0, extra cycles inserted between request acceptance and ack/err (0..15).
REQ-003 Parameter TOHOST_WORD, default 1024, word index of the tohost mailbox.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wb_adr_i  input  32  byte address; bits [1:0] ignored.
REQ-007 wb_dat_i  input  32  write data.
REQ-008 wb_dat_o  output  32  read data, registered.
REQ-009 wb_we_i  input  1  1 = write, 0 = read.
REQ-010 wb_sel_i  input  4  byte-lane enables; bit n covers byte n (little-endian).
REQ-011 wb_cyc_i, wb_stb_i  input  1 each  Wishbone classic cycle/strobe.
REQ-012 wb_ack_o  output  1  normal termination, one-cycle pulse.
REQ-013 wb_err_o  output  1  error termination, one-cycle pulse.
REQ-014 done_o  output  1  sticky; tohost received a nonzero write.
REQ-015 pass_o  output  1  sticky; valid when done_o=1; 1 iff tohost value == 1.
REQ-016 fail_code_o  output  31  sticky; tohost value >> 1, captured with done_o.

Function
REQ-017 FSM states IDLE, WAIT, RESP; one outstanding transaction at most.
REQ-018 IDLE: request accepted when wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o; address, data, we, sel latched at acceptance.
REQ-019 IDLE -> RESP on acceptance when WAIT_STATES=0; IDLE -> WAIT otherwise, wait counter loaded with WAIT_STATES-1.
REQ-020 WAIT: counter decrements each cycle; -> RESP when counter is 0.
REQ-021 WAIT: wb_cyc_i or wb_stb_i low -> IDLE, no memory write, no ack/err, no tohost update (abort).
REQ-022 RESP lasts one cycle: wb_ack_o or wb_err_o high exactly that cycle; -> IDLE next cycle.
REQ-023 Latency: ack/err asserted 1+WAIT_STATES cycles after the acceptance edge (1 cycle at default).
REQ-024 With stb held high continuously, ack/err low for at least one cycle between responses (back-to-back throughput = one transfer per 2+WAIT_STATES cycles).
REQ-025 Out of range: latched adr[31:ADDR_WIDTH+2] nonzero -> wb_err_o instead of wb_ack_o; no write; wb_dat_o holds previous value.
REQ-026 Read: wb_dat_o loaded with mem[adr[ADDR_WIDTH+1:2]] on the edge that asserts wb_ack_o; held until next read ack.
REQ-027 Write: on the edge that asserts wb_ack_o, only lanes with sel bit set are updated; other lanes keep old content; sel=0000 acks with no change.
REQ-028 Tohost: in-range write ack to word TOHOST_WORD whose merged 32-bit result is nonzero while done_o=0 sets done_o=1, pass_o=(value==1), fail_code_o=value[31:1].
REQ-029 Tohost writes of zero, or any write after done_o=1, update memory but not done_o/pass_o/fail_code_o.
REQ-030 Exactly one of ack/err per accepted, non-aborted request; never both.

Reset
REQ-031 rst_n low: state IDLE, wait counter 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, done_o=0, pass_o=0, fail_code_o=0, immediately (asynchronous).
REQ-032 Memory array is not cleared by reset; contents are preloaded by the environment and survive reset.
REQ-033 Reset during WAIT or RESP cancels the transaction; no write is committed after rst_n falls.

Verification
REQ-034 WAIT_STATES=0, mem[5]=0x11223344, read adr 0x14 sel 1111 -> ack one cycle after accept, wb_dat_o=0x11223344, ack low the following cycle.
REQ-035 mem[5]=0x11223344, write adr 0x14 sel 0110 data 0xAABBCCDD -> mem[5]=0x11BBCC44; readback confirms.
REQ-036 WAIT_STATES=3, write to TOHOST_WORD (adr 0x1000) data 0x00000001 -> ack 4 cycles after accept, done_o=1, pass_o=1; later write 0x7 leaves pass_o=1.
REQ-037 Write adr 0x1000 data 0x0000000B -> done_o=1, pass_o=0, fail_code_o=5; preceding write of 0 leaves done_o=0.
REQ-038 Read adr 0x00010000 (ADDR_WIDTH=13) -> wb_err_o pulse, wb_ack_o stays 0, wb_dat_o unchanged.
REQ-039 WAIT_STATES=3, write accepted then stb dropped after 1 cycle -> no ack/err, memory unchanged; rst_n pulsed mid-WAIT -> all outputs 0 at once, memory contents retained.
